// File: rtl/gpio_pkg.sv
// Shared GPIO constants used by the input-conditioning stage and the APB GPIO slave.
package gpio_pkg;

    localparam int GPIO_IN_WIDTH      = 4;
    localparam int GPIO_OUT_WIDTH     = 3;
    localparam int DEBOUNCE_1MS_50MHZ = 50000;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input bit: 2-FF synchroniser, persistence counter, accepted level and edge pulses.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_nxt_o,
    output logic fall_nxt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ, done;

    // Any return to the accepted level restarts the count, so a glitch never accumulates.
    always_comb begin
        differ     = sync2_q ^ stable_q;
        done       = differ && (cnt_q == LAST);
        cnt_d      = (differ && !done) ? cnt_q + CNT_W'(1) : '0;
        stable_d   = done ? sync2_q : stable_q;
        rise_nxt_o = done & sync2_q;
        fall_nxt_o = done & ~sync2_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_nxt_o;
            fall_q   <= fall_nxt_o;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/gpio_in_cond.sv
// Conditions raw board pins for the GPIO slave: debounced levels, edge pulses, sticky IRQ.
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_IN_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    logic [WIDTH-1:0] rise_nxt, fall_nxt;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .PCLK       (PCLK),
            .PRESETn    (PRESETn),
            .pin_i      (pin_in[i]),
            .stable_o   (gpio_i[i]),
            .rise_nxt_o (rise_nxt[i]),
            .fall_nxt_o (fall_nxt[i]),
            .rise_o     (rise_pulse[i]),
            .fall_o     (fall_pulse[i])
        );
    end

    // Set terms are ORed after the clear mask so a new event beats a simultaneous clear.
    always_comb begin
        irq_status_d = (rise_nxt & rise_en) | (fall_nxt & fall_en) | (irq_status_q & ~irq_clr);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) irq_status_q <= '0;
        else          irq_status_q <= irq_status_d;
    end

    assign irq_status = irq_status_q;
    assign irq        = |irq_status_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed scoreboard bench for gpio_in_cond with a short debounce window.
module tb_gpio_in_cond;

    localparam int W = 4;
    localparam int D = 4;

    logic         PCLK = 1'b0;
    logic         PRESETn = 1'b0;
    logic [W-1:0] pin_in = '0, rise_en = '0, fall_en = '0, irq_clr = '0;
    logic [W-1:0] gpio_i, rise_pulse, fall_pulse, irq_status;
    logic         irq;

    gpio_in_cond #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .pin_in(pin_in), .rise_en(rise_en),
        .fall_en(fall_en), .irq_clr(irq_clr), .gpio_i(gpio_i), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .irq_status(irq_status), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int           cyc;
        string        name;
        logic [W-1:0] gpio, rise, fall, irqs;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Monitor: on each falling edge, check every expectation scheduled for this cycle.
    always @(negedge PCLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (e.cyc < cyc) begin
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else if (gpio_i !== e.gpio || rise_pulse !== e.rise || fall_pulse !== e.fall ||
                         irq_status !== e.irqs || irq !== (|e.irqs)) begin
                $display("FAIL %s @%0d: got gpio=%b rise=%b fall=%b irqs=%b irq=%b, want gpio=%b rise=%b fall=%b irqs=%b irq=%b",
                         e.name, cyc, gpio_i, rise_pulse, fall_pulse, irq_status, irq,
                         e.gpio, e.rise, e.fall, e.irqs, |e.irqs);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic expect_at(input int at, input string name, input logic [W-1:0] g,
                             input logic [W-1:0] r, input logic [W-1:0] f, input logic [W-1:0] s);
        exp_t e;
        e.cyc = at; e.name = name; e.gpio = g; e.rise = r; e.fall = f; e.irqs = s;
        q.push_back(e);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        // Reset, release, idle
        tick(3); t = cyc;
        expect_at(t, "in_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        PRESETn = 1'b1;
        expect_at(t + 5,  "idle_5",  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        expect_at(t + 20, "idle_20", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(21);

        // Bit 0 rises, enabled: accepted exactly six edges after being driven
        t = cyc;
        rise_en = 4'b0001; pin_in = 4'b0001;
        expect_at(t + 5, "rise0_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        expect_at(t + 6, "rise0_accept", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        expect_at(t + 7, "rise0_one_cycle", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(8);

        // Bit 1 glitch held for three sampled cycles: rejected
        t = cyc;
        pin_in = 4'b0011;
        expect_at(t + 6, "glitch1_a", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        expect_at(t + 7, "glitch1_b", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        expect_at(t + 9, "glitch1_c", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(3); pin_in = 4'b0001;
        tick(8);

        // Bit 0 falls with fall disabled: pulse but no new flag
        t = cyc;
        pin_in = 4'b0000;
        expect_at(t + 6, "fall0_noirq", 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        tick(8);

        // Clear coinciding with a new enabled rise: set wins; then clear alone
        t = cyc;
        pin_in = 4'b0001;
        expect_at(t + 6, "clr_vs_set", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        expect_at(t + 7, "clr_vs_set_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        expect_at(t + 8, "clr_alone", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tick(5); irq_clr = 4'b0001;
        tick(1); irq_clr = 4'b0000;
        tick(1); irq_clr = 4'b0001;
        tick(1); irq_clr = 4'b0000;
        tick(2);

        // All bits high, then all low: simultaneous falls, only enabled ones flag
        t = cyc;
        rise_en = 4'b0000; fall_en = 4'b1010; pin_in = 4'b1111;
        expect_at(t + 6, "rise_all", 4'b1111, 4'b1110, 4'b0000, 4'b0000);
        tick(8); t = cyc;
        pin_in = 4'b0000;
        expect_at(t + 6, "fall_all", 4'b0000, 4'b0000, 4'b1111, 4'b1010);
        expect_at(t + 7, "fall_all_after", 4'b0000, 4'b0000, 4'b0000, 4'b1010);
        tick(8); t = cyc;
        fall_en = 4'b0000;
        expect_at(t + 2, "en_off_keeps_flag", 4'b0000, 4'b0000, 4'b0000, 4'b1010);
        tick(3);

        // Reset mid-count on bit 2, pin held high through release
        t = cyc;
        rise_en = 4'b0100; pin_in = 4'b0100;
        expect_at(t + 2, "pre_reset", 4'b0000, 4'b0000, 4'b0000, 4'b1010);
        expect_at(t + 3, "async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(3); PRESETn = 1'b0;
        tick(2); PRESETn = 1'b1; t = cyc;
        expect_at(t + 5, "post_reset_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        expect_at(t + 6, "post_reset_rise", 4'b0100, 4'b0100, 4'b0000, 4'b0100);
        expect_at(t + 7, "post_reset_after", 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        tick(10);

        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
